mem_port_arb: RTL
=================

// Module: mem_port_arb
// PURPOSE
// - Two-requester round-robin arbiter for one shared memory/bus port.
// - Typical requesters: instruction fetch (req0) and load/store unit (req1).
// - Owns the select of the shared payload Mux2_1 and sequences each transfer over a valid/ready handshake.
// - Sits between the requesters and the memory interface; the memory side sees a single master.
// PARAMETERS
// - WIDTH  32  payload width: address, write data and control packed by the requester.
// PORTS
// - clk        in   1      system clock; all state changes on the rising edge
// - rst        in   1      synchronous, active-high reset
// - req0       in   1      requester 0 wants the port; level-held until its gnt0
// - payload0   in   WIDTH  requester 0 payload; stable while req0 is high
// - gnt0       out  1      1-cycle pulse: requester 0 transfer accepted
// - req1       in   1      requester 1 request; same rules as req0
// - payload1   in   WIDTH  requester 1 payload
// - gnt1       out  1      1-cycle pulse: requester 1 transfer accepted
// - m_valid    out  1      shared port has a valid transfer
// - m_payload  out  WIDTH  muxed payload of the current owner
// - m_ready    in   1      downstream accepts m_payload this cycle
// - m_sel      out  1      current owner index (0/1); drives Mux2_1 sel
// - busy       out  1      FSM in GRANT state
// BEHAVIOUR
// - Reset (sync, active-high, clk edge with rst=1):
//   - state=IDLE, owner=0, last=1 (req0 wins the first tie).
//   - m_valid=0, gnt0=gnt1=0, busy=0, m_sel=0.
// - FSM, two states, stored owner and last-served pointer:
//   - IDLE: any req high -> choose winner, load owner, go to GRANT next cycle.
//     - 1 cycle arbitration latency; no req -> stay IDLE.
//   - GRANT: m_valid = req_owner; m_payload = payload_owner via Mux2_1.
//     - handshake = m_valid & m_ready.
//     - handshake -> gnt_owner=1 combinationally that same cycle; last <= owner; re-arbitrate in the same cycle.
//       - other req high -> owner <= other, stay GRANT.
//       - else own req still high -> keep owner, stay GRANT (back-to-back).
//       - else -> IDLE.
//     - Sustained throughput: 1 transfer/cycle while m_ready=1.
//   - Owner drops req in GRANT without handshake (abort):
//     - m_valid=0 that cycle, no gnt, FSM -> IDLE; last unchanged.
// - Winner selection:
//   - Only one req high -> that one.
//   - Both high -> the index != last (round robin).
// - gnt0 and gnt1 never both 1; at most one gnt per cycle.
// - m_ready while m_valid=0: ignored.
// - rst mid-transfer: the transfer is dropped, no gnt, all state returns to reset values next edge.
// - m_sel = owner (registered); stable for the full GRANT tenure.
// CONFIGURATION
// - ARB_FIXED_PRIO_EN defined:
//   - Both-high tie always goes to req0; last is ignored.
//   - Re-arbitration on handshake also prefers req0.
// - ARB_FIXED_PRIO_EN undefined (default): round robin as above.
// STRUCTURE
// - Package mem_arb_pkg:
//   - arb_state_t enum {ARB_IDLE, ARB_GRANT}.
//   - localparams REQ_IF=1'b0, REQ_LSU=1'b1.
// - One sub-module: Mux2_1 #(.WIDTH(WIDTH)) for m_payload.
//   - zero=payload0, one=payload1, sel=m_sel.
// - Everything else (FSM, pointer, gnt decode) inline.
// TESTING
// - Reset, then req0=1 payload0=0xA5 with m_ready=1:
//   - cycle+1: m_valid=1, m_payload=0xA5, m_sel=0, gnt0 pulses once.
//   - returns to IDLE after req0 drops.
// - req0 and req1 both held high, m_ready=1 for 6 cycles:
//   - grants alternate 0,1,0,1,0,1; never both gnt in one cycle.
// - req1 only, m_ready=0 for 3 cycles then 1:
//   - m_valid held high 4 cycles with payload1 stable.
//   - gnt1 only in the 4th cycle.
// - In GRANT for owner 0, req0 dropped before m_ready:
//   - m_valid=0 that cycle, no gnt0, busy=0 next cycle.
// - rst asserted while GRANT with m_ready=0:
//   - next cycle all outputs 0.
//   - after release, a first tie goes to req0.
// - ARB_FIXED_PRIO_EN build, both reqs held, m_ready=1 for 4 cycles:
//   - gnt0 every cycle, gnt1 never (starvation expected).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and requester indices for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/Mux2_1.sv
// Two-input payload multiplexer; sel=0 passes zero, sel=1 passes one.
module Mux2_1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] zero,
  input  logic [WIDTH-1:0] one,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y[gi] = sel ? one[gi] : zero[gi];
  end

endmodule

// File: rtl/mem_port_arb.sv
// Two-requester arbiter for one shared memory port with valid/ready sequencing.
// Define ARB_FIXED_PRIO_EN to replace round robin with fixed req0 priority.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] payload0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] payload1,
  output logic             gnt1,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_payload,
  input  logic             m_ready,
  output logic             m_sel,
  output logic             busy
);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       req_owner, req_other, handshake, win;

  assign req_owner = owner_q ? req1 : req0;
  assign req_other = owner_q ? req0 : req1;

  always_comb begin
    win = REQ_IF;
`ifdef ARB_FIXED_PRIO_EN
    win = req0 ? REQ_IF : REQ_LSU;
`else
    if (req0 && req1) win = ~last_q;
    else              win = req1 ? REQ_LSU : REQ_IF;
`endif
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    m_valid   = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    handshake = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (req0 || req1) begin
          owner_d = win;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        m_valid   = req_owner;
        handshake = req_owner && m_ready;
        if (handshake) begin
          gnt0   = (owner_q == REQ_IF);
          gnt1   = (owner_q == REQ_LSU);
          last_d = owner_q;
`ifdef ARB_FIXED_PRIO_EN
          if (req0 || req1) owner_d = win;
          else              state_d = ARB_IDLE;
`else
          if (req_other)      owner_d = ~owner_q;
          else if (!req_owner) state_d = ARB_IDLE;
`endif
        end else if (!req_owner) begin
          // Owner withdrew before the handshake: drop the tenure, pointer untouched.
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= REQ_IF;
      last_q  <= REQ_LSU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign busy  = (state_q == ARB_GRANT);
  assign m_sel = owner_q;

  Mux2_1 #(.WIDTH(WIDTH)) u_mux (
    .zero (payload0),
    .one  (payload1),
    .sel  (m_sel),
    .y    (m_payload)
  );

endmodule
